// File: rtl/blowfish128_feistel.sv
// Blowfish-128 Feistel round controller: holds the P-array and sequences an external F stage.
// Optional BLOWFISH128_DECRYPT_EN adds a Decrypt input that reverses the P-array key order.
module blowfish128_feistel #(
  parameter int ROUNDS = 16
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         PWrEn,
  input  logic [4:0]   PWrAddr,
  input  logic [63:0]  PWrData,
  input  logic         InValid,
  output logic         InReady,
  input  logic [127:0] Din,
`ifdef BLOWFISH128_DECRYPT_EN
  input  logic         Decrypt,
`endif
  output logic [63:0]  FX,
  output logic         FEnable,
  output logic         FAck,
  input  logic [63:0]  FY,
  input  logic         FValid,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [127:0] Dout,
  output logic         Busy
);

  localparam int NP = ROUNDS + 2;
  localparam int CW = $clog2(NP);
  localparam logic [CW-1:0] LAST_CNT = CW'(ROUNDS);
  localparam logic [CW-1:0] TOP_IDX  = CW'(ROUNDS + 1);

  // IDLE wait block | KEY whiten L | FWAIT run F | SWAP exchange halves | FINAL output whitening | DONE hold result
  typedef enum logic [2:0] {IDLE, KEY, FWAIT, SWAP, FINAL, DONE} state_t;

  state_t        state;
  logic [63:0]   p_mem [NP];
  logic [63:0]   l_q;
  logic [63:0]   r_q;
  logic [CW-1:0] cnt;
  logic          dec_q;
  logic          dec_in;
  logic          accept;
  logic          p_we;
  logic [CW-1:0] p_waddr;
  logic [CW-1:0] key_idx;
  logic [63:0]   key_p;
  logic [63:0]   l_key;
  logic [63:0]   fin_l_p;
  logic [63:0]   fin_r_p;

`ifdef BLOWFISH128_DECRYPT_EN
  assign dec_in = Decrypt;
`else
  assign dec_in = 1'b0;
`endif

  assign accept  = InValid && InReady && (state == IDLE);
  assign p_we    = PWrEn && (state == IDLE) && (32'(PWrAddr) <= 32'(ROUNDS + 1));
  assign p_waddr = CW'(PWrAddr);

  assign key_idx = dec_q ? (TOP_IDX - cnt) : cnt;
  assign key_p   = p_mem[key_idx];
  assign l_key   = l_q ^ key_p;
  assign fin_r_p = dec_q ? p_mem[1] : p_mem[ROUNDS];
  assign fin_l_p = dec_q ? p_mem[0] : p_mem[ROUNDS+1];

  // FAck/FEnable decode straight from state so an async reset drops them at once
  assign FEnable = (state == FWAIT);
  assign FAck    = FEnable && FValid;
  assign Busy    = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (p_we) p_mem[p_waddr] <= PWrData;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= IDLE;
      InReady  <= 1'b0;
      OutValid <= 1'b0;
      Dout     <= '0;
      FX       <= '0;
      cnt      <= '0;
      l_q      <= '0;
      r_q      <= '0;
      dec_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          InReady <= 1'b1;
          if (accept) begin
            l_q     <= Din[127:64];
            r_q     <= Din[63:0];
            dec_q   <= dec_in;
            cnt     <= '0;
            InReady <= 1'b0;
            state   <= KEY;
          end
        end
        KEY: begin
          l_q   <= l_key;
          FX    <= l_key;
          state <= FWAIT;
        end
        FWAIT: begin
          if (FValid) begin
            r_q   <= r_q ^ FY;
            state <= SWAP;
          end
        end
        SWAP: begin
          l_q   <= r_q;
          r_q   <= l_q;
          cnt   <= cnt + 1'b1;
          state <= ((cnt + 1'b1) == LAST_CNT) ? FINAL : KEY;
        end
        FINAL: begin
          // last swap undone implicitly: upper half comes from R, lower half from L
          Dout     <= {r_q ^ fin_l_p, l_q ^ fin_r_p};
          OutValid <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          if (OutReady) begin
            OutValid <= 1'b0;
            InReady  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blowfish128_feistel.sv
// Self-checking bench for blowfish128_feistel: C-style reference model plus hand-computed vectors.
// Decrypt round-trip runs only when BLOWFISH128_DECRYPT_EN is defined.
module tb_blowfish128_feistel;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         PWrEn;
  logic [4:0]   PWrAddr;
  logic [63:0]  PWrData;
  logic         InValid;
  logic         InReady;
  logic [127:0] Din;
  logic [63:0]  FX;
  logic         FEnable;
  logic         FAck;
  logic [63:0]  FY;
  logic         FValid;
  logic         OutValid;
  logic         OutReady;
  logic [127:0] Dout;
  logic         Busy;
`ifdef BLOWFISH128_DECRYPT_EN
  logic         dec_drv;
`endif

  blowfish128_feistel #(.ROUNDS(16)) dut (
    .Clk(Clk), .Rst(Rst),
    .PWrEn(PWrEn), .PWrAddr(PWrAddr), .PWrData(PWrData),
    .InValid(InValid), .InReady(InReady), .Din(Din),
`ifdef BLOWFISH128_DECRYPT_EN
    .Decrypt(dec_drv),
`endif
    .FX(FX), .FEnable(FEnable), .FAck(FAck), .FY(FY), .FValid(FValid),
    .OutValid(OutValid), .OutReady(OutReady), .Dout(Dout), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  localparam logic [127:0] LIT1_DIN = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] LIT1_OUT = 128'h8899AABBCCDDEEFF0011223344556677;
  localparam logic [127:0] LIT2_OUT = 128'h000000000002DB6D000000000001B6DB;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           acc_cyc  = 0;
  int           fack_cnt = 0;
  logic [63:0]  pm [18];
  logic [127:0] exp_dout;
  logic [127:0] last_dout;

  // F-function stub: Y=0 or Y=X, FValid after f_lat cycles of FEnable, optional stray FValid
  int  f_lat  = 3;
  bit  f_mode = 1'b0;
  bit  f_spur = 1'b0;
  int  f_cnt  = 0;

  always @(posedge Clk) begin
    if (!FEnable || FAck) f_cnt <= 0;
    else                  f_cnt <= f_cnt + 1;
  end
  always @(posedge Clk) cyc <= cyc + 1;

  assign FValid = (FEnable && (f_cnt == f_lat - 1)) || (f_spur && !FEnable);
  assign FY     = !FEnable ? 64'hA5A5_5A5A_DEAD_BEEF : (f_mode ? FX : 64'h0);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  function automatic logic [63:0] f_fn(input logic [63:0] x);
    return f_mode ? x : 64'h0;
  endfunction

  function automatic logic [127:0] bf_model(input logic [127:0] din, input bit dec);
    logic [63:0] l, r, t;
    l = din[127:64];
    r = din[63:0];
    for (int i = 0; i < 16; i++) begin
      l = l ^ (dec ? pm[17-i] : pm[i]);
      r = r ^ f_fn(l);
      t = l; l = r; r = t;
    end
    t = l; l = r; r = t;
    r = r ^ (dec ? pm[1] : pm[16]);
    l = l ^ (dec ? pm[0] : pm[17]);
    return {l, r};
  endfunction

  task automatic pwrite(input logic [4:0] a, input logic [63:0] d, input bit lands);
    @(negedge Clk);
    PWrEn = 1'b1; PWrAddr = a; PWrData = d;
    @(posedge Clk);
    #1 PWrEn = 1'b0;
    if (lands && a <= 5'd17) pm[a] = d;
  endtask

  task automatic send(input logic [127:0] d, input bit dec, input bit wr,
                      input logic [4:0] wa, input logic [63:0] wd);
    int n = 0;
    @(negedge Clk);
    while (!InReady && n < 300) begin @(negedge Clk); n++; end
    if (!InReady) begin timeout_fail("accept"); return; end
    Din = d; InValid = 1'b1;
`ifdef BLOWFISH128_DECRYPT_EN
    dec_drv = dec;
`endif
    if (wr) begin
      PWrEn = 1'b1; PWrAddr = wa; PWrData = wd;
      if (wa <= 5'd17) pm[wa] = wd;
    end
    exp_dout = bf_model(d, dec);
    @(posedge Clk);
    #1;
    acc_cyc = cyc;
    InValid = 1'b0; PWrEn = 1'b0;
  endtask

  task automatic collect(input string nm, input int hold);
    int n = 0;
    @(negedge Clk);
    while (!OutValid && n < 3000) begin @(negedge Clk); n++; end
    if (!OutValid) begin timeout_fail({nm, "_outvalid"}); return; end
    last_dout = Dout;
    chk({nm, "_latency"}, 128'(cyc - acc_cyc), 128'(2*16 + 16*f_lat + 1));
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      chk({nm, "_hold_outvalid"}, 128'(OutValid), 128'(1));
      chk({nm, "_hold_inready"}, 128'(InReady), 128'(0));
    end
    OutReady = 1'b1;
    @(posedge Clk);
    #1 OutReady = 1'b0;
    @(negedge Clk);
    chk({nm, "_release_outvalid"}, 128'(OutValid), 128'(0));
    chk({nm, "_release_inready"}, 128'(InReady), 128'(1));
  endtask

  // compare process: every cycle out of reset
  initial begin : cmp
    logic         prev_ov;
    logic         prev_fen;
    logic [127:0] prev_dout;
    logic [63:0]  prev_fx;
    prev_ov = 1'b0; prev_fen = 1'b0; prev_dout = '0; prev_fx = '0;
    forever begin
      @(negedge Clk);
      if (Rst) begin
        prev_ov = 1'b0; prev_fen = 1'b0;
      end else begin
        chk("fack_rule", 128'(FAck), 128'(FEnable && FValid));
        if (OutValid) begin
          chk("dout_vs_model", Dout, exp_dout);
          chk("inready_while_outvalid", 128'(InReady), 128'(0));
          if (prev_ov) chk("dout_stable", Dout, prev_dout);
        end
        if (FEnable && prev_fen) chk("fx_stable", 128'(FX), 128'(prev_fx));
        if (FAck) fack_cnt++;
        prev_ov = OutValid; prev_dout = Dout; prev_fen = FEnable; prev_fx = FX;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    int n;
    logic [127:0] enc;
    Rst = 1'b1; PWrEn = 1'b0; PWrAddr = '0; PWrData = '0;
    InValid = 1'b0; Din = '0; OutReady = 1'b0;
`ifdef BLOWFISH128_DECRYPT_EN
    dec_drv = 1'b0;
`endif
    for (int i = 0; i < 18; i++) pm[i] = '0;

    repeat (3) @(negedge Clk);
    chk("rst_inready", 128'(InReady), 128'(0));
    chk("rst_outvalid", 128'(OutValid), 128'(0));
    chk("rst_dout", Dout, 128'h0);
    chk("rst_fx", 128'(FX), 128'(0));
    chk("rst_fenable", 128'(FEnable), 128'(0));
    chk("rst_fack", 128'(FAck), 128'(0));
    chk("rst_busy", 128'(Busy), 128'(0));
    Rst = 1'b0;
    @(negedge Clk);
    chk("inready_after_release", 128'(InReady), 128'(1));

    // all-zero key, Y=0: only the final half swap survives
    for (int i = 0; i < 18; i++) pwrite(5'(i), 64'h0, 1'b1);
    f_mode = 1'b0; f_lat = 3;
    chk("model_pin_zero", bf_model(LIT1_DIN, 1'b0), LIT1_OUT);
    send(LIT1_DIN, 1'b0, 1'b0, '0, '0);
    collect("zero_key", 0);
    chk("zero_key_literal", last_dout, LIT1_OUT);

    // single-cycle F with stray FValid outside FWAIT
    f_lat = 1; f_spur = 1'b1;
    send(128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100, 1'b0, 1'b0, '0, '0);
    collect("fast_f_spur", 0);
    chk("fast_f_spur_literal", last_dout, 128'h7766554433221100_FFEEDDCCBBAA9988);
    f_spur = 1'b0;

    // one-hot key, Y=X, with back-pressure
    for (int i = 0; i < 18; i++) pwrite(5'(i), 64'h1 << i, 1'b1);
    f_mode = 1'b1; f_lat = 2;
    chk("model_pin_onehot", bf_model(128'h0, 1'b0), LIT2_OUT);
    base = fack_cnt;
    send(128'h0, 1'b0, 1'b0, '0, '0);
    collect("onehot", 10);
    chk("onehot_literal", last_dout, LIT2_OUT);
    chk("onehot_fack_count", 128'(fack_cnt - base), 128'(16));

    // write to P[0] while busy must be dropped
    send(128'h0, 1'b0, 1'b0, '0, '0);
    pwrite(5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    collect("busy_write", 0);
    chk("busy_write_literal", last_dout, LIT2_OUT);
    // out-of-range address in IDLE changes nothing
    pwrite(5'd18, 64'hFFFF_0000_FFFF_0000, 1'b1);
    send(128'h0, 1'b0, 1'b0, '0, '0);
    collect("addr18_write", 0);
    chk("addr18_literal", last_dout, LIT2_OUT);

    // write and accept in the same cycle: block sees the new P[5]
    send(128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0, 1'b1, 5'd5, 64'h1234_5678_9ABC_DEF0);
    collect("write_with_accept", 0);

    // reset during round 7 FWAIT
    f_lat = 3;
    base = fack_cnt;
    send(128'hCAFEBABE_0BADF00D_DEADBEEF_8BADF00D, 1'b0, 1'b0, '0, '0);
    n = 0;
    @(negedge Clk);
    while (!(FEnable && (fack_cnt - base) == 7) && n < 1000) begin @(negedge Clk); n++; end
    if (!(FEnable && (fack_cnt - base) == 7)) timeout_fail("round7_fwait");
    Rst = 1'b1;
    #1;
    chk("midrst_fenable", 128'(FEnable), 128'(0));
    chk("midrst_fack", 128'(FAck), 128'(0));
    chk("midrst_outvalid", 128'(OutValid), 128'(0));
    chk("midrst_busy", 128'(Busy), 128'(0));
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    repeat (3) @(negedge Clk);
    chk("midrst_no_outvalid", 128'(OutValid), 128'(0));
    send(128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 1'b0, 1'b0, '0, '0);
    collect("after_reset", 0);

`ifdef BLOWFISH128_DECRYPT_EN
    enc = bf_model(LIT1_DIN, 1'b0);
    send(LIT1_DIN, 1'b0, 1'b0, '0, '0);
    collect("dec_encrypt", 0);
    send(enc, 1'b1, 1'b0, '0, '0);
    collect("dec_decrypt", 0);
    chk("decrypt_roundtrip", last_dout, LIT1_DIN);
`else
    enc = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
